// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: generic ROWS x COLS time-multiplexed LED matrix driver.
// Each row gets a slot of L = scan_div+1 cycles: Be blank cycles followed by
// L-Be drive cycles with PWM-gated columns. Frame and brightness are captured
// at every frame start so a frame is never torn.
module led_matrix_scanner #(
    parameter int ROWS  = 6,
    parameter int COLS  = 6,
    parameter int DIV_W = 12,
    parameter int PWM_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] frame,
    input  logic [DIV_W-1:0]     scan_div,
    input  logic [DIV_W-1:0]     blank_cycles,
    input  logic [PWM_W-1:0]     brightness,
    output logic [ROWS-1:0]      rows,
    output logic [COLS-1:0]      columns,
    output logic                 frame_start
);

    localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t                 state, next_state;
    logic [RIDX_W-1:0]      row_idx, next_row_idx;
    logic [DIV_W-1:0]       slot_cnt, next_slot_cnt;
    logic [DIV_W-1:0]       slot_last, next_slot_last;
    logic [DIV_W-1:0]       blank_len, next_blank_len;
    logic                   blank_all, next_blank_all;
    logic [PWM_W-1:0]       pwm_cnt, next_pwm_cnt;
    logic [PWM_W-1:0]       bright_snap, next_bright_snap;
    logic [ROWS*COLS-1:0]   frame_snap, next_frame_snap;
    logic [ROWS-1:0]        next_rows;
    logic [COLS-1:0]        next_columns;
    logic                   next_frame_start;
    logic                   slot_start;
    logic                   pwm_on;

    // Next-state, slot sequencing and registered-output decode.
    // slot_cnt counts from 0 to slot_last inclusive, so a DIV_W-bit counter
    // covers the longest slot (2^DIV_W cycles) without overflow. blank_all
    // marks slots whose blank length reaches the slot length, i.e. Be = L.
    always_comb begin
        next_state       = state;
        next_row_idx     = row_idx;
        next_slot_cnt    = slot_cnt + 1'b1;
        next_slot_last   = slot_last;
        next_blank_len   = blank_len;
        next_blank_all   = blank_all;
        next_frame_snap  = frame_snap;
        next_bright_snap = bright_snap;
        next_frame_start = 1'b0;
        next_pwm_cnt     = '0;
        next_rows        = '0;
        next_columns     = '0;
        slot_start       = 1'b0;
        pwm_on           = 1'b0;

        case (state)
            BLANK, DRIVE: begin
                if (!enable) begin
                    next_state    = IDLE;
                    next_row_idx  = '0;
                    next_slot_cnt = '0;
                end else if (slot_cnt == slot_last) begin
                    slot_start   = 1'b1;
                    next_row_idx = (row_idx == RIDX_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;
                end else if (state == BLANK && !blank_all && next_slot_cnt == blank_len) begin
                    next_state = DRIVE;
                end
            end
            default: begin
                next_state    = IDLE;
                next_row_idx  = '0;
                next_slot_cnt = '0;
                if (enable) begin
                    slot_start = 1'b1;
                end
            end
        endcase

        if (slot_start) begin
            next_slot_cnt  = '0;
            next_slot_last = scan_div;
            next_blank_len = blank_cycles;
            next_blank_all = (blank_cycles > scan_div);
            next_state     = (blank_cycles == '0) ? DRIVE : BLANK;
            if (next_row_idx == '0) begin
                next_frame_snap  = frame;
                next_bright_snap = brightness;
                next_frame_start = 1'b1;
            end
        end

        if (next_state == DRIVE && state == DRIVE && !slot_start) begin
            next_pwm_cnt = pwm_cnt + 1'b1;
        end

        pwm_on = (next_pwm_cnt < next_bright_snap) || (next_bright_snap == '1);

        if (next_state == DRIVE) begin
            next_rows    = ROWS'(1) << next_row_idx;
            next_columns = next_frame_snap[int'(next_row_idx) * COLS +: COLS] & {COLS{pwm_on}};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Slot counters, snapshots and registered pad outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_idx     <= '0;
            slot_cnt    <= '0;
            slot_last   <= '0;
            blank_len   <= '0;
            blank_all   <= 1'b0;
            pwm_cnt     <= '0;
            bright_snap <= '0;
            frame_snap  <= '0;
            rows        <= '0;
            columns     <= '0;
            frame_start <= 1'b0;
        end else begin
            row_idx     <= next_row_idx;
            slot_cnt    <= next_slot_cnt;
            slot_last   <= next_slot_last;
            blank_len   <= next_blank_len;
            blank_all   <= next_blank_all;
            pwm_cnt     <= next_pwm_cnt;
            bright_snap <= next_bright_snap;
            frame_snap  <= next_frame_snap;
            rows        <= next_rows;
            columns     <= next_columns;
            frame_start <= next_frame_start;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: scoreboard bench for led_matrix_scanner. A slot-timeline
// reference model predicts each cycle's pad outputs; a monitor compares them.
module tb_led_matrix_scanner;

    localparam int ROWS    = 6;
    localparam int COLS    = 6;
    localparam int DIV_W   = 12;
    localparam int PWM_W   = 4;
    localparam int NPIX    = ROWS * COLS;
    localparam int PWM_MOD = 1 << PWM_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [NPIX-1:0]  frame = '0;
    logic [DIV_W-1:0] scan_div = '0;
    logic [DIV_W-1:0] blank_cycles = '0;
    logic [PWM_W-1:0] brightness = '0;
    logic [ROWS-1:0]  rows;
    logic [COLS-1:0]  columns;
    logic             frame_start;

    int error_count = 0;
    int check_count = 0;
    int cycle_no = 0;

    typedef struct packed {
        logic [ROWS-1:0] rows;
        logic [COLS-1:0] columns;
        logic            fs;
    } expect_t;

    expect_t exp_q[$];

    bit              m_active = 1'b0;
    int              m_row = 0;
    int              m_t = 0;
    int              m_len = 1;
    int              m_be = 0;
    int              m_bright = 0;
    logic [NPIX-1:0] m_snap = '0;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DIV_W(DIV_W), .PWM_W(PWM_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .frame(frame),
        .scan_div(scan_div),
        .blank_cycles(blank_cycles),
        .brightness(brightness),
        .rows(rows),
        .columns(columns),
        .frame_start(frame_start)
    );

    // Free-running scan clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        check_count++;
        if (got !== want) begin
            error_count++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle_no, got, want);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_start_slot(input int r);
        m_active = 1'b1;
        m_row    = r;
        m_t      = 0;
        m_len    = int'(scan_div) + 1;
        m_be     = (int'(blank_cycles) < m_len) ? int'(blank_cycles) : m_len;
        if (r == 0) begin
            m_snap   = frame;
            m_bright = int'(brightness);
        end
    endtask

    // Reference model: tracks position inside the current slot and predicts outputs.
    always @(posedge clk or posedge reset) begin
        expect_t e;
        int d;
        if (reset) begin
            m_active = 1'b0;
            m_row    = 0;
            m_t      = 0;
            exp_q.delete();
        end else begin
            cycle_no++;
            if (!m_active) begin
                if (enable) model_start_slot(0);
            end else if (!enable) begin
                m_active = 1'b0;
            end else begin
                m_t++;
                if (m_t >= m_len) model_start_slot((m_row + 1) % ROWS);
            end
            e = '0;
            if (m_active) begin
                e.fs = (m_t == 0 && m_row == 0);
                if (m_t >= m_be) begin
                    e.rows = ROWS'(1) << m_row;
                    d = m_t - m_be;
                    if ((d % PWM_MOD) < m_bright || m_bright == PWM_MOD - 1)
                        e.columns = m_snap[m_row * COLS +: COLS];
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compares the DUT outputs against the oldest prediction each cycle.
    always @(posedge clk) begin
        expect_t e;
        #1;
        if (!reset) begin
            if (exp_q.size() == 0) begin
                check_count++;
                error_count++;
                $display("[TB] FAIL scoreboard at cycle %0d: got no prediction, expected one", cycle_no);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rows", 64'(rows), 64'(e.rows));
                checkOutput("columns", 64'(columns), 64'(e.columns));
                checkOutput("frame_start", 64'(frame_start), 64'(e.fs));
            end
        end
    end

    task automatic wait_rows(input logic [ROWS-1:0] target, input int budget);
        int n = 0;
        while (rows !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (rows !== target) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL wait_rows: got %b, expected %b within %0d cycles", rows, target, budget);
        end
    endtask

    task automatic wait_frame_start(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < budget);
        if (frame_start !== 1'b1) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL wait_frame_start: got no pulse, expected one within %0d cycles", budget);
        end
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed phases followed by randomized traffic.
    initial begin
        int n;

        reset = 1'b1;
        applyStimulus(3);
        checkOutput("reset_rows", 64'(rows), 64'd0);
        checkOutput("reset_columns", 64'(columns), 64'd0);
        checkOutput("reset_frame_start", 64'(frame_start), 64'd0);

        $display("[TB] basic scan");
        scan_div = 3; blank_cycles = 1; brightness = 15; frame = '1;
        reset = 1'b0; enable = 1'b1;
        wait_frame_start(5, n);
        checkOutput("enable_latency", 64'(n), 64'd1);
        wait_frame_start(60, n);
        checkOutput("frame_period", 64'(n), 64'd24);
        applyStimulus(30);

        $display("[TB] tear-free update");
        frame = NPIX'({$urandom(), $urandom()});
        applyStimulus(24);
        wait_rows(6'b000100, 100);
        frame = NPIX'({$urandom(), $urandom()});
        applyStimulus(60);

        $display("[TB] pwm");
        scan_div = 19; blank_cycles = 0; brightness = 4; frame = '1;
        applyStimulus(160);
        brightness = 0;
        applyStimulus(260);
        brightness = PWM_W'($urandom());
        frame = NPIX'({$urandom(), $urandom()});
        applyStimulus(250);

        $display("[TB] blank boundary");
        scan_div = 3; blank_cycles = 9; brightness = 15;
        applyStimulus(140);
        wait_frame_start(200, n);
        wait_frame_start(60, n);
        checkOutput("blank_frame_period", 64'(n), 64'd24);

        $display("[TB] enable drop");
        blank_cycles = 1;
        wait_rows(6'b010000, 200);
        enable = 1'b0;
        applyStimulus(3);
        checkOutput("idle_rows", 64'(rows), 64'd0);
        enable = 1'b1;
        applyStimulus(1);
        checkOutput("restart_frame_start", 64'(frame_start), 64'd1);
        applyStimulus(40);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) frame = NPIX'({$urandom(), $urandom()});
            if ($urandom_range(0, 19) == 0) brightness = PWM_W'($urandom());
            if ($urandom_range(0, 29) == 0) scan_div = DIV_W'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) blank_cycles = DIV_W'($urandom_range(0, 9));
            enable = ($urandom_range(0, 99) != 0);
        end

        $display("[TB] longest slot");
        enable = 1'b1; scan_div = '1; blank_cycles = DIV_W'(4095); brightness = 15; frame = '1;
        applyStimulus(4200);
        enable = 1'b0;
        applyStimulus(2);

        $display("[TB] async reset mid-drive");
        scan_div = 3; blank_cycles = 1; brightness = 15;
        frame = NPIX'({$urandom(), $urandom()});
        enable = 1'b1;
        wait_rows(6'b000010, 100);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_rows", 64'(rows), 64'd0);
        checkOutput("async_reset_columns", 64'(columns), 64'd0);
        checkOutput("async_reset_frame_start", 64'(frame_start), 64'd0);
        applyStimulus(2);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("post_reset_frame_start", 64'(frame_start), 64'd1);
        checkOutput("post_reset_rows", 64'(rows), 64'd0);
        applyStimulus(50);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
